// File: rtl/arm_pipe_controller.sv
// arm_pipe_controller
// Control unit for a 5-stage pipelined ARM core. It decodes the instruction
// in Decode, carries the control word through the E/M/W pipeline registers,
// holds the NZCV flags and evaluates the condition code in Execute. The
// condition result gates every write enable and the branch.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   Cond/Op/Funct/Rd      instruction fields in Decode
//   FlushE                turns the D->E load into a bubble
//   ALUFlags              NZCV produced by the ALU in Execute
//   ImmSrcD, RegSrcD      combinational Decode controls
//   ALUControlE, ALUSrcE  Execute datapath controls
//   BranchTakenE          conditional branch resolved in Execute
//   MemtoRegE             load in Execute (load-use detection)
//   MemWriteM, RegWriteM  Memory-stage enables
//   RegWriteW, MemtoRegW  Writeback-stage controls
//   PCSrcW                PC loaded from the result in Writeback
//   PCWrPendingF          a PC write is in D, E or M
//   Flags                 current NZCV
module arm_pipe_controller #(
  parameter int ALUCTRL_W = 4,
  parameter bit COND_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 FlushE,
  input  logic [3:0]           ALUFlags,
  output logic [1:0]           ImmSrcD,
  output logic [1:0]           RegSrcD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 BranchTakenE,
  output logic                 MemtoRegE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic                 PCWrPendingF,
  output logic [3:0]           Flags
);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0100);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0010);

  // Decode
  logic                 w_reg_write_d, w_mem_write_d, w_memtoreg_d;
  logic                 w_alu_src_d, w_branch_d, w_pcs_d, w_bx_d;
  logic [ALUCTRL_W-1:0] w_alu_ctrl_d;
  logic [1:0]           w_flag_write_d;

  always_comb begin
    w_reg_write_d  = 1'b0;
    w_mem_write_d  = 1'b0;
    w_memtoreg_d   = 1'b0;
    w_alu_src_d    = 1'b0;
    w_branch_d     = 1'b0;
    w_bx_d         = 1'b0;
    w_alu_ctrl_d   = '0;
    w_flag_write_d = 2'b00;
    ImmSrcD        = 2'b00;
    RegSrcD        = 2'b00;
    case (Op)
      2'b00: begin
        w_alu_src_d = Funct[5];
        case (Funct[4:1])
          4'b0100, 4'b0010: begin
            w_alu_ctrl_d   = ALUCTRL_W'(Funct[4:1]);
            w_reg_write_d  = 1'b1;
            w_flag_write_d = Funct[0] ? 2'b11 : 2'b00;
          end
          4'b0000, 4'b1100, 4'b1101: begin
            w_alu_ctrl_d   = ALUCTRL_W'(Funct[4:1]);
            w_reg_write_d  = 1'b1;
            w_flag_write_d = Funct[0] ? 2'b10 : 2'b00;
          end
          4'b1010: begin
            w_alu_ctrl_d   = ALU_SUB;
            w_flag_write_d = 2'b11;
          end
          4'b1001: w_bx_d = 1'b1;
          default: ;
        endcase
      end
      2'b01: begin
        w_alu_src_d  = 1'b1;
        ImmSrcD      = 2'b01;
        w_alu_ctrl_d = Funct[3] ? ALU_ADD : ALU_SUB;
        if (Funct[0]) begin
          w_reg_write_d = 1'b1;
          w_memtoreg_d  = 1'b1;
        end else begin
          w_mem_write_d = 1'b1;
          RegSrcD       = 2'b10;
        end
      end
      2'b10: begin
        w_branch_d    = 1'b1;
        ImmSrcD       = 2'b10;
        w_alu_src_d   = 1'b1;
        w_alu_ctrl_d  = ALU_ADD;
        RegSrcD       = 2'b01;
        w_reg_write_d = Funct[4];
      end
      default: ;
    endcase
    // Writing R15 from a DP op or a load redirects the PC; BL writes R14.
    w_pcs_d = w_bx_d | (w_reg_write_d & ~Op[1] & (Rd == 4'hF));
  end

  // D->E register
  logic                 r_reg_write_e, r_mem_write_e, r_memtoreg_e;
  logic                 r_alu_src_e, r_branch_e, r_pcs_e;
  logic [ALUCTRL_W-1:0] r_alu_ctrl_e;
  logic [1:0]           r_flag_write_e;
  logic [3:0]           r_cond_e;
  logic [3:0]           r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write_e  <= 1'b0;
      r_mem_write_e  <= 1'b0;
      r_memtoreg_e   <= 1'b0;
      r_alu_src_e    <= 1'b0;
      r_branch_e     <= 1'b0;
      r_pcs_e        <= 1'b0;
      r_alu_ctrl_e   <= '0;
      r_flag_write_e <= 2'b00;
      r_cond_e       <= 4'h0;
    end else begin
      // ALU control and condition still load on a flush; with every enable
      // cleared they have no effect.
      r_alu_ctrl_e <= w_alu_ctrl_d;
      r_alu_src_e  <= w_alu_src_d;
      r_cond_e     <= Cond;
      if (FlushE) begin
        r_reg_write_e  <= 1'b0;
        r_mem_write_e  <= 1'b0;
        r_memtoreg_e   <= 1'b0;
        r_branch_e     <= 1'b0;
        r_pcs_e        <= 1'b0;
        r_flag_write_e <= 2'b00;
      end else begin
        r_reg_write_e  <= w_reg_write_d;
        r_mem_write_e  <= w_mem_write_d;
        r_memtoreg_e   <= w_memtoreg_d;
        r_branch_e     <= w_branch_d;
        r_pcs_e        <= w_pcs_d;
        r_flag_write_e <= w_flag_write_d;
      end
    end
  end

  // Condition evaluation against the current flags
  logic w_n, w_z, w_c, w_v, w_cond_tab, w_cond_ex;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    case (r_cond_e)
      4'b0000: w_cond_tab = w_z;
      4'b0001: w_cond_tab = ~w_z;
      4'b0010: w_cond_tab = w_c;
      4'b0011: w_cond_tab = ~w_c;
      4'b0100: w_cond_tab = w_n;
      4'b0101: w_cond_tab = ~w_n;
      4'b0110: w_cond_tab = w_v;
      4'b0111: w_cond_tab = ~w_v;
      4'b1000: w_cond_tab = w_c & ~w_z;
      4'b1001: w_cond_tab = ~w_c | w_z;
      4'b1010: w_cond_tab = (w_n == w_v);
      4'b1011: w_cond_tab = (w_n != w_v);
      4'b1100: w_cond_tab = ~w_z & (w_n == w_v);
      4'b1101: w_cond_tab = w_z | (w_n != w_v);
      default: w_cond_tab = 1'b1;
    endcase
  end

  assign w_cond_ex = COND_EN ? w_cond_tab : 1'b1;

  logic w_reg_write_ge, w_mem_write_ge, w_pcsrc_ge;
  assign w_reg_write_ge = r_reg_write_e & w_cond_ex;
  assign w_mem_write_ge = r_mem_write_e & w_cond_ex;
  assign w_pcsrc_ge     = r_pcs_e & w_cond_ex;

  // Flags and E->M / M->W registers
  logic r_pcsrc_m, r_memtoreg_m;
  logic r_reg_write_m, r_mem_write_m;
  logic r_reg_write_w, r_memtoreg_w, r_pcsrc_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags       <= 4'h0;
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_memtoreg_m  <= 1'b0;
      r_pcsrc_m     <= 1'b0;
      r_reg_write_w <= 1'b0;
      r_memtoreg_w  <= 1'b0;
      r_pcsrc_w     <= 1'b0;
    end else begin
      if (r_flag_write_e[1] & w_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
      if (r_flag_write_e[0] & w_cond_ex) r_flags[1:0] <= ALUFlags[1:0];
      r_reg_write_m <= w_reg_write_ge;
      r_mem_write_m <= w_mem_write_ge;
      r_memtoreg_m  <= r_memtoreg_e;
      r_pcsrc_m     <= w_pcsrc_ge;
      r_reg_write_w <= r_reg_write_m;
      r_memtoreg_w  <= r_memtoreg_m;
      r_pcsrc_w     <= r_pcsrc_m;
    end
  end

  assign ALUControlE  = r_alu_ctrl_e;
  assign ALUSrcE      = r_alu_src_e;
  assign BranchTakenE = r_branch_e & w_cond_ex;
  assign MemtoRegE    = r_memtoreg_e;
  assign MemWriteM    = r_mem_write_m;
  assign RegWriteM    = r_reg_write_m;
  assign RegWriteW    = r_reg_write_w;
  assign MemtoRegW    = r_memtoreg_w;
  assign PCSrcW       = r_pcsrc_w;
  assign PCWrPendingF = w_pcs_d | r_pcs_e | r_pcsrc_m;
  assign Flags        = r_flags;

endmodule

// File: tb/tb_arm_pipe_controller.sv
// Directed bench for arm_pipe_controller. Expectations are queued with the
// cycle at which they become visible and checked on the falling edge.
module tb_arm_pipe_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FlushE;

  logic [1:0] ImmSrcD, RegSrcD;
  logic [3:0] ALUControlE;
  logic ALUSrcE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM;
  logic RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;
  logic [3:0] Flags;

  logic [1:0] n_ImmSrcD, n_RegSrcD;
  logic [3:0] n_ALUControlE;
  logic n_ALUSrcE, n_BranchTakenE, n_MemtoRegE, n_MemWriteM, n_RegWriteM;
  logic n_RegWriteW, n_MemtoRegW, n_PCSrcW, n_PCWrPendingF;
  logic [3:0] n_Flags;

  always #5 clk = ~clk;

  arm_pipe_controller #(.ALUCTRL_W(4), .COND_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlushE(FlushE), .ALUFlags(ALUFlags), .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BranchTakenE(BranchTakenE),
    .MemtoRegE(MemtoRegE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .PCWrPendingF(PCWrPendingF), .Flags(Flags));

  arm_pipe_controller #(.ALUCTRL_W(4), .COND_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlushE(FlushE), .ALUFlags(ALUFlags), .ImmSrcD(n_ImmSrcD), .RegSrcD(n_RegSrcD),
    .ALUControlE(n_ALUControlE), .ALUSrcE(n_ALUSrcE), .BranchTakenE(n_BranchTakenE),
    .MemtoRegE(n_MemtoRegE), .MemWriteM(n_MemWriteM), .RegWriteM(n_RegWriteM),
    .RegWriteW(n_RegWriteW), .MemtoRegW(n_MemtoRegW), .PCSrcW(n_PCSrcW),
    .PCWrPendingF(n_PCWrPendingF), .Flags(n_Flags));

  localparam int S_IMM = 0, S_REGSRC = 1, S_ALUCTL = 2, S_ALUSRC = 3, S_BRT = 4,
                 S_M2RE = 5, S_MWM = 6, S_RWM = 7, S_RWW = 8, S_M2RW = 9,
                 S_PCSW = 10, S_PCWP = 11, S_FLAGS = 12, S_BRT_NC = 13;

  localparam logic [3:0] AL = 4'b1110;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NOP = 2'b11;
  localparam logic [5:0] F_ADD  = 6'b001000, F_ADDS = 6'b001001, F_SUBS = 6'b000101;
  localparam logic [5:0] F_CMP  = 6'b010101, F_B = 6'b100000, F_BL = 6'b110000;
  localparam logic [5:0] F_LDR_UP = 6'b011001, F_LDR_DN = 6'b010001, F_STR = 6'b011000;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t keep_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_IMM:    return {6'b0, ImmSrcD};
      S_REGSRC: return {6'b0, RegSrcD};
      S_ALUCTL: return {4'b0, ALUControlE};
      S_ALUSRC: return {7'b0, ALUSrcE};
      S_BRT:    return {7'b0, BranchTakenE};
      S_M2RE:   return {7'b0, MemtoRegE};
      S_MWM:    return {7'b0, MemWriteM};
      S_RWM:    return {7'b0, RegWriteM};
      S_RWW:    return {7'b0, RegWriteW};
      S_M2RW:   return {7'b0, MemtoRegW};
      S_PCSW:   return {7'b0, PCSrcW};
      S_PCWP:   return {7'b0, PCWrPendingF};
      S_FLAGS:  return {4'b0, Flags};
      S_BRT_NC: return {7'b0, n_BranchTakenE};
      default:  return 8'hxx;
    endcase
  endfunction

  // Reference condition evaluation: ARM pairs each condition with its
  // inverse in bit 0, so evaluate the even member and invert on odd codes.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    {n, z, cc, v} = f;
    base = 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  always @(negedge clk) begin
    logic [7:0] o;
    keep_q = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        o = obs(sb[i].sel);
        n_tests++;
        assert (o === sb[i].exp) else begin
          n_fail++;
          $error("FAIL %s (cycle %0d): observed %0h expected %0h", sb[i].tag, cyc, o, sb[i].exp);
        end
      end else begin
        keep_q.push_back(sb[i]);
      end
    end
    sb = keep_q;
  end

  task automatic drive(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic fl, input logic [3:0] af);
    Cond = c; Op = op; Funct = f; Rd = rd; FlushE = fl; ALUFlags = af;
  endtask

  task automatic nop(input logic [3:0] af);
    drive(AL, OP_NOP, 6'b0, 4'h0, 1'b0, af);
  endtask

  task automatic chk(input int off, input int sel, input logic [7:0] e, input string tag);
    exp_t x;
    x.due = cyc + off; x.sel = sel; x.exp = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin nop(4'h0); tick(); end
  endtask

  initial begin
    reset = 1'b1;
    nop(4'h0);
    tick();

    // Reset held two cycles with ADDS in Decode
    drive(AL, OP_DP, F_ADDS, 4'h2, 1'b0, 4'h0);
    chk(0, S_RWW, 0, "rst_rww"); chk(0, S_MWM, 0, "rst_mwm");
    chk(0, S_FLAGS, 0, "rst_flags"); chk(0, S_ALUCTL, 0, "rst_aluctl");
    tick();
    chk(0, S_RWW, 0, "rst_rww2"); chk(0, S_FLAGS, 0, "rst_flags2");
    tick();
    reset = 1'b0;
    chk(0, S_RWW, 0, "post_rst_rww"); chk(0, S_RWM, 0, "post_rst_rwm");
    chk(1, S_ALUCTL, 8'h4, "add_aluctl"); chk(3, S_RWW, 1, "add_rww");
    tick();
    idle(3);

    // SUBS sets Z, BEQ taken; then SUBS clears Z, BEQ not taken
    drive(AL, OP_DP, F_SUBS, 4'h3, 1'b0, 4'h0);
    chk(1, S_ALUSRC, 0, "subs_alusrc"); chk(1, S_ALUCTL, 8'h2, "subs_aluctl");
    tick();
    drive(4'b0000, OP_BR, F_B, 4'h0, 1'b0, 4'b0100);
    chk(0, S_IMM, 8'h2, "b_immsrc"); chk(0, S_REGSRC, 8'h1, "b_regsrc");
    chk(1, S_FLAGS, 8'h4, "subs_flags_z"); chk(1, S_BRT, 1, "beq_taken");
    chk(1, S_ALUSRC, 1, "b_alusrc");
    tick();
    nop(4'h0); tick();
    drive(AL, OP_DP, F_SUBS, 4'h3, 1'b0, 4'h0);
    tick();
    drive(4'b0000, OP_BR, F_B, 4'h0, 1'b0, 4'b0000);
    chk(1, S_FLAGS, 8'h0, "subs_flags_0"); chk(1, S_BRT, 0, "beq_not_taken");
    tick();
    idle(2);

    // Condition table: CMP loads NZCV, conditional B reads it next cycle
    for (int v = 0; v < 16; v++) begin
      for (int c = 0; c < 16; c++) begin
        drive(AL, OP_DP, F_CMP, 4'h0, 1'b0, 4'h0);
        tick();
        drive(4'(c), OP_BR, F_B, 4'h0, 1'b0, 4'(v));
        chk(1, S_BRT, {7'b0, cond_eval(4'(c), 4'(v))}, $sformatf("cond_c%0d_f%0d", c, v));
        chk(1, S_BRT_NC, 1, $sformatf("nocond_c%0d_f%0d", c, v));
        tick();
      end
    end
    idle(2);

    // Store and load
    drive(AL, OP_MEM, F_STR, 4'h4, 1'b0, 4'h0);
    chk(0, S_REGSRC, 8'h2, "str_regsrc"); chk(0, S_IMM, 8'h1, "str_immsrc");
    chk(1, S_MWM, 0, "str_mwm_early"); chk(2, S_MWM, 1, "str_mwm");
    chk(3, S_MWM, 0, "str_mwm_late"); chk(3, S_RWW, 0, "str_rww");
    #1;
    n_tests++;
    if (RegSrcD !== 2'b10) begin
      n_fail++;
      $error("FAIL str_regsrc_direct: observed %0h expected 2", RegSrcD);
    end
    n_tests++;
    if (ImmSrcD !== 2'b01) begin
      n_fail++;
      $error("FAIL str_immsrc_direct: observed %0h expected 1", ImmSrcD);
    end
    tick();
    idle(3);
    drive(AL, OP_MEM, F_LDR_DN, 4'h5, 1'b0, 4'h0);
    chk(1, S_ALUCTL, 8'h2, "ldr_dn_aluctl"); chk(1, S_M2RE, 1, "ldr_m2re");
    chk(3, S_M2RW, 1, "ldr_m2rw"); chk(3, S_RWW, 1, "ldr_rww");
    chk(0, S_PCWP, 0, "ldr_r5_pcwp");
    tick();
    idle(3);

    // Flush: bubbles carry no enables and never write flags (flags = 1111)
    drive(AL, OP_DP, F_CMP, 4'h0, 1'b1, 4'h0);
    tick();
    drive(AL, OP_MEM, F_LDR_UP, 4'h5, 1'b1, 4'h0);
    chk(1, S_FLAGS, 8'hF, "flush_cmp_flags");
    chk(1, S_M2RE, 0, "flush_ldr_m2re"); chk(2, S_RWM, 0, "flush_ldr_rwm");
    chk(3, S_RWW, 0, "flush_ldr_rww"); chk(3, S_M2RW, 0, "flush_ldr_m2rw");
    tick();
    drive(AL, OP_MEM, F_STR, 4'h4, 1'b1, 4'h0);
    chk(2, S_MWM, 0, "flush_str_mwm");
    tick();
    idle(3);

    // Flush arriving while SUBS is in Execute: SUBS completes
    drive(AL, OP_DP, F_SUBS, 4'h3, 1'b0, 4'h0);
    tick();
    drive(AL, OP_NOP, 6'b0, 4'h0, 1'b1, 4'b0010);
    chk(1, S_FLAGS, 8'h2, "flush_subs_flags"); chk(1, S_RWM, 1, "flush_subs_rwm");
    tick();
    idle(3);

    // Condition gating: Z=0 so ADDEQ is dropped and ADDNE writes
    drive(4'b0000, OP_DP, F_ADD, 4'h6, 1'b0, 4'h0);
    chk(3, S_RWW, 0, "addeq_rww");
    tick();
    idle(3);
    drive(4'b0001, OP_DP, F_ADD, 4'h6, 1'b0, 4'h0);
    chk(3, S_RWW, 1, "addne_rww");
    tick();
    idle(3);

    // LDR into PC
    drive(AL, OP_MEM, F_LDR_UP, 4'hF, 1'b0, 4'h0);
    chk(0, S_PCWP, 1, "ldrpc_pcwp_d"); chk(1, S_PCWP, 1, "ldrpc_pcwp_e");
    chk(2, S_PCWP, 1, "ldrpc_pcwp_m"); chk(3, S_PCWP, 0, "ldrpc_pcwp_w");
    chk(3, S_PCSW, 1, "ldrpc_pcsw"); chk(4, S_PCSW, 0, "ldrpc_pcsw_after");
    #1;
    n_tests++;
    if (PCWrPendingF !== 1'b1) begin
      n_fail++;
      $error("FAIL ldrpc_pcwp_direct: observed %0h expected 1", PCWrPendingF);
    end
    tick();
    idle(4);

    // BL: links and branches, but is not a PC write from the result
    drive(AL, OP_BR, F_BL, 4'h0, 1'b0, 4'h0);
    chk(0, S_PCWP, 0, "bl_pcwp"); chk(1, S_BRT, 1, "bl_brt");
    chk(3, S_RWW, 1, "bl_rww"); chk(3, S_PCSW, 0, "bl_pcsw");
    #1;
    n_tests++;
    if (RegSrcD !== 2'b01) begin
      n_fail++;
      $error("FAIL bl_regsrc_direct: observed %0h expected 1", RegSrcD);
    end
    tick();
    idle(3);

    // Reset mid-stream discards in-flight control
    drive(AL, OP_DP, F_ADDS, 4'h2, 1'b0, 4'h0);
    tick();
    drive(AL, OP_MEM, F_STR, 4'h4, 1'b0, 4'h0);
    tick();
    reset = 1'b1;
    nop(4'h0);
    chk(1, S_RWM, 0, "midrst_rwm"); chk(1, S_MWM, 0, "midrst_mwm");
    chk(1, S_RWW, 0, "midrst_rww"); chk(1, S_FLAGS, 0, "midrst_flags");
    tick();
    reset = 1'b0;
    idle(3);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %0h by cycle %0d", sb[i].tag, sb[i].exp, sb[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
